// File: rtl/calc_seq_bcd.sv
// calc_seq_bcd: sequential calculator. It captures two W-bit operands on a
// key press and computes add, subtract, multiply (shift-add) or divide
// (restoring division). The result goes through a sequential double-dabble
// converter and is shown on seven-segment digits with blanking, a minus
// sign and an error indication.
module calc_seq_bcd #(
    parameter int W      = 5,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    input  logic [2*W-1:0]        SW,
    input  logic [3:0]            KEY,
    output logic [2*W-1:0]        LEDR,
    output logic                  NEG,
    output logic                  ERR,
    output logic                  BUSY,
    output logic [7*DIGITS-1:0]   HEX
);
    localparam int RW = 2 * W;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(RW + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [7*DIGITS-1:0] HEX_RESET = {{(DIGITS-1){7'b1111111}}, 7'b1000000};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_EXEC = 3'd1, S_MUL = 3'd2,
        S_DIV  = 3'd3, S_BCD  = 3'd4, S_LOAD = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3
    } op_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0] LIM_POS = pow10(DIGITS);
    localparam logic [63:0] LIM_NEG = pow10(DIGITS - 1);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
    function automatic logic [BW+RW-1:0] dabble(input logic [BW+RW-1:0] v);
        logic [BW+RW-1:0] t;
        t = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[RW+4*d +: 4] >= 4'd5) begin
                t[RW+4*d +: 4] = t[RW+4*d +: 4] + 4'd3;
            end else begin
                t[RW+4*d +: 4] = t[RW+4*d +: 4];
            end
        end
        return t << 1;
    endfunction

    logic [3:0]        key_meta_r, key_sync_r, key_prev_r;
    logic [3:0]        press_s;
    op_t               op_s, op_r;
    state_t            state_r, state_s;
    logic [W-1:0]      a_r, b_r, quo_r, rem_r;
    logic [RW-1:0]     mcand_r, r_r, bin_r;
    logic [BW-1:0]     bcd_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_r, div0_r;
    logic [RW-1:0]     add_s, diff_s, prod_next_s;
    logic [W:0]        rem_shift_s, rem_diff_s;
    logic              div_ge_s;
    logic [W-1:0]      quo_next_s;
    logic [BW+RW-1:0]  dd_next_s;
    logic              it_last_s, bcd_last_s, ovf_s, err_s;
    logic [7*DIGITS-1:0] hex_s;
    int                msd_s;

    // A press is a high-to-low step on the synchronised key; flops reset low
    // so a key held through reset does not count as a press.
    assign press_s = key_prev_r & ~key_sync_r;

    // Two-flop key synchroniser plus edge-detect history.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            key_meta_r <= 4'b0000;
            key_sync_r <= 4'b0000;
            key_prev_r <= 4'b0000;
        end else begin
            key_meta_r <= KEY;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
        end
    end

    // Opcode selection with fixed priority KEY0 > KEY1 > KEY2 > KEY3.
    always_comb begin
        op_s = OP_DIV;
        if (press_s[0]) begin
            op_s = OP_ADD;
        end else if (press_s[1]) begin
            op_s = OP_SUB;
        end else if (press_s[2]) begin
            op_s = OP_MUL;
        end else begin
            op_s = OP_DIV;
        end
    end

    assign add_s       = {{W{1'b0}}, a_r} + {{W{1'b0}}, b_r};
    assign diff_s      = (a_r >= b_r) ? {{W{1'b0}}, a_r - b_r} : {{W{1'b0}}, b_r - a_r};
    assign prod_next_s = r_r + (b_r[0] ? mcand_r : {RW{1'b0}});
    // Partial remainder stays below 2*B, so W+1 bits hold it and the
    // subtraction's top bit is the borrow.
    assign rem_shift_s = {rem_r, quo_r[W-1]};
    assign rem_diff_s  = rem_shift_s - {1'b0, b_r};
    assign div_ge_s    = ~rem_diff_s[W];
    assign quo_next_s  = {quo_r[W-2:0], div_ge_s};
    assign dd_next_s   = dabble({bcd_r, bin_r});
    assign it_last_s   = (cnt_r == CW'(W - 1));
    assign bcd_last_s  = (cnt_r == CW'(RW - 1));
    assign ovf_s       = ({{(64-RW){1'b0}}, r_r} >= LIM_POS) ||
                         (neg_r && ({{(64-RW){1'b0}}, r_r} >= LIM_NEG));
    assign err_s       = div0_r | ovf_s;

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (|press_s) state_s = S_EXEC;
                else          state_s = S_IDLE;
            end
            S_EXEC: begin
                case (op_r)
                    OP_ADD, OP_SUB: state_s = S_BCD;
                    OP_MUL:         state_s = S_MUL;
                    OP_DIV: begin
                        if (b_r == {W{1'b0}}) state_s = S_LOAD;
                        else                  state_s = S_DIV;
                    end
                    default:        state_s = S_IDLE;
                endcase
            end
            S_MUL: begin
                if (it_last_s) state_s = S_BCD;
                else           state_s = S_MUL;
            end
            S_DIV: begin
                if (it_last_s) state_s = S_BCD;
                else           state_s = S_DIV;
            end
            S_BCD: begin
                if (bcd_last_s) state_s = S_LOAD;
                else            state_s = S_BCD;
            end
            S_LOAD:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: operand capture, arithmetic iterations and BCD conversion.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            op_r    <= OP_ADD;
            quo_r   <= {W{1'b0}};
            rem_r   <= {W{1'b0}};
            mcand_r <= {RW{1'b0}};
            r_r     <= {RW{1'b0}};
            bin_r   <= {RW{1'b0}};
            bcd_r   <= {BW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            neg_r   <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (|press_s) begin
                        a_r  <= SW[2*W-1:W];
                        b_r  <= SW[W-1:0];
                        op_r <= op_s;
                    end
                end
                S_EXEC: begin
                    cnt_r  <= {CW{1'b0}};
                    bcd_r  <= {BW{1'b0}};
                    neg_r  <= 1'b0;
                    div0_r <= 1'b0;
                    case (op_r)
                        OP_ADD: begin
                            r_r   <= add_s;
                            bin_r <= add_s;
                        end
                        OP_SUB: begin
                            r_r   <= diff_s;
                            bin_r <= diff_s;
                            neg_r <= (a_r < b_r);
                        end
                        OP_MUL: begin
                            r_r     <= {RW{1'b0}};
                            mcand_r <= {{W{1'b0}}, a_r};
                        end
                        OP_DIV: begin
                            quo_r <= a_r;
                            rem_r <= {W{1'b0}};
                            if (b_r == {W{1'b0}}) begin
                                div0_r <= 1'b1;
                                r_r    <= {RW{1'b1}};
                            end
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    r_r     <= prod_next_s;
                    mcand_r <= mcand_r << 1;
                    b_r     <= b_r >> 1;
                    if (it_last_s) begin
                        bin_r <= prod_next_s;
                        cnt_r <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_DIV: begin
                    quo_r <= quo_next_s;
                    rem_r <= div_ge_s ? rem_diff_s[W-1:0] : rem_shift_s[W-1:0];
                    if (it_last_s) begin
                        r_r   <= {{W{1'b0}}, quo_next_s};
                        bin_r <= {{W{1'b0}}, quo_next_s};
                        cnt_r <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                S_BCD: begin
                    {bcd_r, bin_r} <= dd_next_s;
                    cnt_r          <= cnt_r + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Seven-segment image of the finished BCD value, sign and error.
    always_comb begin
        hex_s = {(7*DIGITS){1'b1}};
        msd_s = 0;
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_r[4*i +: 4] != 4'd0) msd_s = i;
            else                         msd_s = msd_s;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (err_s) begin
                hex_s[7*i +: 7] = (i == 0) ? SEG_E : SEG_BLANK;
            end else if (i <= msd_s) begin
                hex_s[7*i +: 7] = seg7(bcd_r[4*i +: 4]);
            end else if (neg_r && (i == msd_s + 1)) begin
                hex_s[7*i +: 7] = SEG_MINUS;
            end else begin
                hex_s[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    // Registered outputs: BUSY follows capture/LOAD; results change only in LOAD.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            LEDR <= {RW{1'b0}};
            NEG  <= 1'b0;
            ERR  <= 1'b0;
            BUSY <= 1'b0;
            HEX  <= HEX_RESET;
        end else if ((state_r == S_IDLE) && (|press_s)) begin
            BUSY <= 1'b1;
        end else if (state_r == S_LOAD) begin
            BUSY <= 1'b0;
            LEDR <= r_r;
            NEG  <= neg_r;
            ERR  <= err_s;
            HEX  <= hex_s;
        end else begin
            BUSY <= BUSY;
        end
    end

endmodule
